// File: rtl/dino_player_ctrl.sv
// Dino player state sequencer: sprite state code, fixed-point jump height, score enable.
// Optional DINO_SHORT_HOP_EN: releasing jump while rising cuts the ascent short.
module dino_player_ctrl #(
    parameter int Y_W        = 6,
    parameter int JUMP_VEL   = 7,
    parameter int GRAVITY    = 1,
    parameter int ANIM_TICKS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_game_tick,
    input  logic           i_jump,
    input  logic           i_duck,
    input  logic           i_collision,
    input  logic           i_restart,
    output logic [2:0]     o_player_state,
    output logic [Y_W-1:0] o_player_y,
    output logic           o_score_en
);

    localparam int AW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
    localparam logic [AW-1:0]     ANIM_LAST = AW'(ANIM_TICKS - 1);
    localparam logic signed [Y_W:0] JUMP_V  = (Y_W + 1)'(JUMP_VEL);
    localparam logic signed [Y_W:0] GRAV_V  = (Y_W + 1)'(GRAVITY);

    typedef enum logic [2:0] {
        RESTART   = 3'b000,
        JUMPING   = 3'b001,
        RUNNING_1 = 3'b010,
        RUNNING_2 = 3'b011,
        DUCKING   = 3'b100,
        GAME_OVER = 3'b101
    } state_t;

    state_t                 state;
    logic [Y_W-1:0]         y;
    logic signed [Y_W:0]    vel;
    logic signed [Y_W:0]    vel_eff;
    logic [AW-1:0]          anim;
    logic signed [Y_W+1:0]  sum;
    logic                   land;
    logic                   sat;

    always_comb begin
        vel_eff = vel;
`ifdef DINO_SHORT_HOP_EN
        if (!i_jump && !vel[Y_W] && (vel != '0)) vel_eff = '0;
`endif
        // Two extra bits keep y + vel exact: one for sign, one for overflow past 2^Y_W-1
        sum  = $signed({2'b00, y}) + $signed({vel_eff[Y_W], vel_eff});
        land = sum[Y_W+1] || (sum == '0);
        sat  = sum[Y_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RESTART;
            y          <= '0;
            vel        <= '0;
            anim       <= '0;
            o_score_en <= 1'b0;
        end else begin
            case (state)
                RESTART: begin
                    if (i_jump) begin
                        state      <= RUNNING_1;
                        anim       <= '0;
                        y          <= '0;
                        o_score_en <= 1'b1;
                    end
                end
                GAME_OVER: begin
                    if (i_restart) begin
                        state      <= RESTART;
                        y          <= '0;
                        vel        <= '0;
                        anim       <= '0;
                        o_score_en <= 1'b0;
                    end
                end
                default: begin
                    if (i_collision) begin
                        state      <= GAME_OVER;
                        o_score_en <= 1'b0;
                    end else if (i_game_tick) begin
                        case (state)
                            RUNNING_1, RUNNING_2: begin
                                if (i_jump) begin
                                    state <= JUMPING;
                                    vel   <= JUMP_V;
                                end else if (i_duck) begin
                                    state <= DUCKING;
                                    anim  <= '0;
                                end else if (anim == ANIM_LAST) begin
                                    state <= (state == RUNNING_1) ? RUNNING_2 : RUNNING_1;
                                    anim  <= '0;
                                end else begin
                                    anim <= anim + 1'b1;
                                end
                            end
                            DUCKING: begin
                                if (i_jump) begin
                                    state <= JUMPING;
                                    vel   <= JUMP_V;
                                end else if (!i_duck) begin
                                    state <= RUNNING_1;
                                    anim  <= '0;
                                end
                            end
                            JUMPING: begin
                                if (land) begin
                                    state <= RUNNING_1;
                                    y     <= '0;
                                    vel   <= '0;
                                    anim  <= '0;
                                end else begin
                                    y   <= sat ? '1 : sum[Y_W-1:0];
                                    vel <= vel_eff - GRAV_V;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign o_player_state = state;
    assign o_player_y     = y;

endmodule

// File: doc/dino_player_ctrl.md
Name: dino_player_ctrl

Overview:
Player state sequencer for the dino game. It drives the 3-bit player-state code consumed by the sprite ROM, so it selects the run-frame alternation, jump, duck, restart and game-over sprites. It computes the dino's vertical offset with fixed-point jump physics, advanced once per frame tick. It sits between the input debouncers/collision detector and the sprite ROM/renderer.

Parameters:
Y_W, 6, width of o_player_y (unsigned height above ground, pixels)
JUMP_VEL, 7, initial upward velocity loaded at jump start (px/tick)
GRAVITY, 1, velocity decrement per tick
ANIM_TICKS, 4, ticks per run frame before RUNNING_1/RUNNING_2 toggle (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_game_tick  in  1  one-clk pulse per game frame
i_jump  in  1  jump button level (debounced)
i_duck  in  1  duck button level (debounced)
i_collision  in  1  obstacle overlap level from collision detector
i_restart  in  1  restart request level
o_player_state  out  3  000 RESTART, 001 JUMPING, 010 RUNNING_1, 011 RUNNING_2, 100 DUCKING, 101 GAME_OVER
o_player_y  out  Y_W  height above ground
o_score_en  out  1  high in JUMPING/RUNNING_1/RUNNING_2/DUCKING

Behaviour:
- Reset (rst_n low, async): state=RESTART, o_player_y=0, internal vel=0, anim counter=0, o_score_en=0. Reset mid-jump behaves identically.
- All outputs are registered; a state change is visible one clk after the qualifying edge.
- vel: signed, Y_W+1 bits. Position update: sum = y + vel, computed signed at Y_W+2 bits.
- Priority each clk, evaluated in order:
  1. i_collision high in any state except RESTART/GAME_OVER -> GAME_OVER. Tick not required. y and vel freeze.
  2. Tick-qualified transitions, listed per state below.
- RESTART: i_jump high on any clk -> RUNNING_1, anim=0, y=0. i_collision is ignored.
- GAME_OVER: i_restart high on any clk -> RESTART, y=0, vel=0, anim=0. All other inputs are ignored.
- RUNNING_1/RUNNING_2, on tick:
  - i_jump high -> JUMPING, vel=JUMP_VEL, y unchanged (0). Jump wins over duck.
  - else i_duck high -> DUCKING, anim=0.
  - else anim+1. When anim==ANIM_TICKS-1, toggle RUNNING_1<->RUNNING_2 and clear anim.
- DUCKING, on tick:
  - i_jump -> JUMPING, vel=JUMP_VEL.
  - else i_duck low -> RUNNING_1, anim=0.
  - else stay.
- JUMPING, on tick:
  - If sum<=0 -> y=0, vel=0, RUNNING_1, anim=0 (landing).
  - Else y=sum, saturated at 2^Y_W-1; then vel=vel-GRAVITY.
  - i_jump and i_duck are ignored (base build).
- Without a tick, nothing changes except by rules 1, RESTART and GAME_OVER above.
- Collision on the same clk as tick: collision wins. y keeps its pre-tick value.
- Collision and jump together in RESTART: go to RUNNING_1 (collision is ignored in RESTART).

Optional Feature:
Macro DINO_SHORT_HOP_EN.
- Defined: in JUMPING, on a tick with i_jump low and vel>0, vel is forced to 0 before the position update. y holds that tick, then vel becomes -GRAVITY, giving a variable-height jump.
- Undefined: jump height is fixed and i_jump is ignored while airborne.

Test Plan:
- Reset, then i_jump for 1 clk -> RUNNING_1. With 8 ticks (ANIM_TICKS=4), state toggles to RUNNING_2 after the 4th tick and back to RUNNING_1 after the 8th; o_score_en=1.
- RUNNING_1, i_jump on a tick, then 15 further ticks -> o_player_y = 7,13,18,22,25,27,28,28,27,25,22,18,13,7,0. The state is RUNNING_1 after the 15th tick.
- JUMPING at y=22, i_collision high between ticks -> GAME_OVER next clk, y stays 22. Later ticks change nothing. i_restart -> RESTART, y=0, o_score_en=0.
- i_duck held over 3 ticks -> DUCKING. i_duck and i_jump together on a tick -> JUMPING, vel=7. Release duck while running -> RUNNING_1 on next tick.
- (DINO_SHORT_HOP_EN) Jump, release i_jump after 3 ticks (y=18) -> subsequent y = 18,17,15,12,8,3,0, then RUNNING_1.
- Assert rst_n low mid-jump at y=25 -> immediate RESTART, y=0 without waiting for clk. Deassert, then i_jump -> RUNNING_1.
